// File: rtl/icache_pkg.sv
// Shared geometry, types and FSM encoding for the direct-mapped instruction cache.
// Address split: offset = [3:0], index = [9:4], tag = [31:10] with the default geometry.
package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int LINE_W         = 128;
    localparam int LINES          = 64;
    localparam int BEAT_W         = 32;

    localparam int OFFSET_BITS    = $clog2(LINE_W / 8);
    localparam int INDEX_BITS     = $clog2(LINES);
    localparam int TAG_BITS       = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int BEATS          = LINE_W / BEAT_W;
    localparam int BEAT_BITS      = $clog2(BEATS);
    localparam int BEAT_BYTE_BITS = $clog2(BEAT_W / 8);
    localparam int LINE_ADDR_BITS = ADDR_W - OFFSET_BITS;

    typedef logic [TAG_BITS-1:0]            tag_t;
    typedef logic [INDEX_BITS-1:0]          index_t;
    typedef logic [LINE_ADDR_BITS-1:0]      line_addr_t;
    typedef logic [BEAT_BITS-1:0]           beat_t;
    typedef logic [BEATS-1:0][BEAT_W-1:0]   line_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    function automatic index_t line_index(input line_addr_t line_addr);
        return line_addr[INDEX_BITS-1:0];
    endfunction

    function automatic tag_t line_tag(input line_addr_t line_addr);
        return line_addr[LINE_ADDR_BITS-1 -: TAG_BITS];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: one combinational read port, one synchronous
// write port, and a flash clear of all valid bits that wins over a write.
module icache_array
    import icache_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output line_t  rd_data,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  line_t  wr_data,
    input  logic   clear
);

    logic [LINES-1:0] valid;
    tag_t             tag_mem  [LINES];
    line_t            data_mem [LINES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hit lookup, and on a miss a
// four-beat refill from a pipelined 32-bit memory port through a line buffer.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int DATA_WIDTH     = LINE_W,
    parameter int NUM_LINES      = LINES,
    parameter int MEM_DATA_WIDTH = BEAT_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     cache_addr,
    input  logic                      cache_rd,
    output logic [DATA_WIDTH-1:0]     cache_data,
    output logic                      cache_waitrequest,
    input  logic                      inv_all,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_rd,
    input  logic                      mem_waitrequest,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
    input  logic                      mem_rdatavalid
);

    localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

    state_t     state, state_nxt;
    line_addr_t req_line;
    line_addr_t miss_line;
    beat_t      issue_cnt, recv_cnt;
    logic       issue_done;
    line_t      line_buf;

    logic       rd_valid;
    tag_t       rd_tag;
    line_t      rd_data;

    logic       hit, miss_start, beat_accept, beat_recv, last_recv;
    logic       unused_offset;

    assign req_line      = cache_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offset = ^cache_addr[OFFSET_BITS-1:0];

    icache_array u_array (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_index (line_index(req_line)),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (state == WRITE),
        .wr_index (line_index(miss_line)),
        .wr_tag   (line_tag(miss_line)),
        .wr_data  (line_buf),
        .clear    (inv_all)
    );

    assign hit        = cache_rd & rd_valid & (rd_tag == line_tag(req_line)) & (state == IDLE);
    assign miss_start = (state == IDLE) & cache_rd & ~hit;

    // Gated by reset_n so fetch never sees a stall while this block is held in reset.
    assign cache_waitrequest = reset_n & cache_rd & ~hit;
    assign cache_data        = hit ? rd_data : '0;

    assign mem_rd      = (state == FILL) & ~issue_done;
    assign mem_addr    = mem_rd ? {miss_line, issue_cnt, {BEAT_BYTE_BITS{1'b0}}} : '0;
    assign beat_accept = mem_rd & ~mem_waitrequest;
    assign beat_recv   = (state == FILL) & mem_rdatavalid;
    assign last_recv   = beat_recv & (recv_cnt == LAST_BEAT);

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_start) state_nxt = FILL;
            FILL:    if (last_recv)  state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            miss_line  <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            recv_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                miss_line  <= req_line;
                issue_cnt  <= '0;
                issue_done <= 1'b0;
                recv_cnt   <= '0;
            end else begin
                if (beat_accept) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == LAST_BEAT) issue_done <= 1'b1;
                end
                if (beat_recv) recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

    // Beat 0 lands in the most significant word, so the slot is the inverted beat number.
    always_ff @(posedge clock) begin
        if (beat_recv) line_buf[~recv_cnt] <= mem_rdata;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache.
- Responds to the instruction fetch unit's line-read interface. On a hit it returns a 128-bit, 4-instruction line in the same cycle. On a miss it holds waitrequest and refills the line from a 32-bit pipelined memory port.
- Sits between the fetch stage and the instruction memory/bus arbiter.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- DATA_WIDTH, 128, line width returned to fetch (4 words).
- NUM_LINES, 64, number of cache lines; power of two.
- MEM_DATA_WIDTH, 32, memory beat width; beats per line = DATA_WIDTH/MEM_DATA_WIDTH = 4.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset.
- cache_addr  in  ADDR_WIDTH  fetch byte address; bits [3:0] ignored for lookup.
- cache_rd  in  1  fetch read request.
- cache_data  out  DATA_WIDTH  line; word at offset 0 in [127:96], offset 1 in [95:64], offset 2 in [63:32], offset 3 in [31:0].
- cache_waitrequest  out  1  high while the line is not available.
- inv_all  in  1  single-cycle pulse; invalidate all lines.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address.
- mem_rd  out  1  beat read request.
- mem_waitrequest  in  1  memory not accepting; mem_rd/mem_addr must be held.
- mem_rdata  in  MEM_DATA_WIDTH  returned beat.
- mem_rdatavalid  in  1  mem_rdata valid; responses arrive in issue order.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clock.
  - All valid bits cleared; FSM enters IDLE; beat counters cleared.
  - mem_rd=0, mem_addr=0, cache_waitrequest=0, cache_data=0.
  - Tag/data arrays are not reset.
- Address split: offset=[3:0], index=[3+log2(NUM_LINES):4], tag=remaining upper bits.
- Lookup is combinational from register arrays.
  - hit = cache_rd & valid[index] & (tag_array[index]==tag) & state==IDLE.
  - cache_waitrequest = cache_rd & ~hit.
  - cache_data = data_array[index] when hit, else 0.
  - cache_rd=0: cache_waitrequest=0 and no miss is started.
- FSM states:
  - IDLE: on cache_rd & ~hit, latch the line address (addr[ADDR_WIDTH-1:4]) into miss_line and go to FILL.
  - FILL:
    - mem_rd=1 and mem_addr={miss_line, issue_cnt, 2'b00} while issue_cnt<4.
    - issue_cnt increments on mem_rd & ~mem_waitrequest.
    - Each mem_rdatavalid writes mem_rdata into line-buffer word recv_cnt; recv_cnt then increments.
    - Beat 0 (lowest address) goes to [127:96].
    - When the 4th beat is received, go to WRITE.
  - WRITE: one cycle. Write the line buffer into data_array, the tag into tag_array, and set valid, all at miss_line's index. Then go to IDLE.
  - The lookup hits in IDLE on the following cycle if cache_addr is unchanged.
- cache_waitrequest stays 1 throughout FILL and WRITE.
- Miss penalty with zero-wait memory and 1-cycle read latency:
  - miss detected cycle T; beats issued T+1..T+4; data returned T+2..T+5.
  - WRITE at T+6; hit with waitrequest=0 at T+7.
- mem_addr/mem_rd are held stable while mem_waitrequest=1. mem_rd drops in the cycle after the 4th acceptance.
- The fill always completes for miss_line, even if cache_addr changes mid-fill. The address is re-evaluated in IDLE.
- inv_all clears all valid bits next edge. Priority over WRITE: if both occur in the same cycle, the written line ends invalid. A fill in progress continues to completion.
- Beat counters are 2-bit with a separate done flag. No wrap re-issue.
- Reset mid-fill: FSM returns to IDLE. Late memory responses after reset are not supported; the system resets memory together with this block.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, FILL, WRITE}.
  - Localparams for OFFSET_BITS, INDEX_BITS, TAG_BITS, BEATS, derived from the parameters.
  - Typedefs tag_t, index_t, line_t.
- Sub-module icache_array:
  - Tag, valid and data storage.
  - One combinational read port.
  - One synchronous write port.
  - Flash-clear input for valid bits.
- icache_dm holds the FSM, counters and line buffer.

Test Plan:
- Cold miss: after reset, cache_rd=1, cache_addr=0x0000_1000, zero-wait memory with 1-cycle latency returning 0xA0,0xA1,0xA2,0xA3 → mem_addr sequence 0x1000,0x1004,0x1008,0x100C; waitrequest=1 for 7 cycles; then cache_data=0x000000A0_000000A1_000000A2_000000A3 with waitrequest=0.
- Hit with unaligned address: then cache_addr=0x0000_1008 → same-cycle hit, same line, no mem_rd.
- Conflict: cache_addr=0x0000_1400 (same index, different tag with NUM_LINES=64) → miss and refill; a later access to 0x1000 misses again.
- Memory backpressure: mem_waitrequest=1 for 3 cycles on beat 2 → mem_addr stays 0x1008 and mem_rd stays high; line data is still correct.
- Invalidate: inv_all pulse after a fill → next access to 0x1000 misses. inv_all coincident with WRITE → the line is not valid afterwards.
- Reset mid-fill: assert reset_n=0 after 2 beats → mem_rd=0 and waitrequest=0 immediately; the next access to 0x1000 misses.
